// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 pipeline controller: opcodes, controller
// states, memory-interface encodings and the instruction class record.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_WRITE = 2'd1;
  localparam logic [1:0] MS_IND   = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_MEM_IND = 3'd1,
    ST_MEM_RW  = 3'd2,
    ST_BR1     = 3'd3,
    ST_BR2     = 3'd4
  } state_e;

  typedef struct packed {
    logic is_alu;
    logic is_lea;
    logic is_load;
    logic is_store;
    logic is_indirect;
    logic is_control;
    logic is_jmp;
  } op_class_t;

endpackage

// File: rtl/lc3_op_classify.sv
// Decodes the opcode field of a 16-bit LC-3 instruction into class flags.
module lc3_op_classify
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] instr_i,
  output op_class_t   cls_o
);

  logic [3:0] op_s;
  logic       unused_s;

  assign op_s     = instr_i[15:12];
  // Operand fields carry no class information.
  assign unused_s = ^instr_i[11:0];

  assign cls_o.is_alu      = (op_s == OP_ADD) || (op_s == OP_AND) || (op_s == OP_NOT);
  assign cls_o.is_lea      = (op_s == OP_LEA);
  assign cls_o.is_load     = (op_s == OP_LD) || (op_s == OP_LDR) || (op_s == OP_LDI);
  assign cls_o.is_store    = (op_s == OP_ST) || (op_s == OP_STR) || (op_s == OP_STI);
  assign cls_o.is_indirect = (op_s == OP_LDI) || (op_s == OP_STI);
  assign cls_o.is_control  = (op_s == OP_BR) || (op_s == OP_JMP);
  assign cls_o.is_jmp      = (op_s == OP_JMP);

endmodule

// File: rtl/lc3_controller.sv
// LC-3 pipeline controller: stage enables, memory-access stalls and the
// two-cycle branch bubble, all decoded from a small state register.
module lc3_controller
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatePC,
  output logic        br_taken,
  output logic [1:0]  mem_state
);

  state_e    state_q, state_d;
  op_class_t ir_cls_s, exec_cls_s, imem_cls_s;
  logic      unused_s;

  lc3_op_classify u_ir_cls   (.instr_i(IR),        .cls_o(ir_cls_s));
  lc3_op_classify u_exec_cls (.instr_i(IR_Exec),   .cls_o(exec_cls_s));
  lc3_op_classify u_imem_cls (.instr_i(IMem_dout), .cls_o(imem_cls_s));

  assign unused_s = ^{ir_cls_s, exec_cls_s, imem_cls_s, IR_Exec[8:0]};

  // Next-state and output decode; reset forces idle outputs and a return to RUN.
  always_comb begin
    state_d          = state_q;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    enable_updatePC  = 1'b0;
    br_taken         = 1'b0;
    mem_state        = MS_IDLE;
    if (reset) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (complete_instr) begin
            enable_fetch     = 1'b1;
            enable_decode    = 1'b1;
            enable_execute   = 1'b1;
            enable_writeback = 1'b1;
            enable_updatePC  = 1'b1;
            // A memory op in Execute outranks a control op arriving in Decode.
            if (ir_cls_s.is_load || ir_cls_s.is_store) begin
              state_d = ir_cls_s.is_indirect ? ST_MEM_IND : ST_MEM_RW;
            end else if (imem_cls_s.is_control) begin
              state_d = ST_BR1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MEM_IND: begin
          mem_state = MS_IND;
          if (complete_data) begin
            state_d = ST_MEM_RW;
          end else begin
            state_d = ST_MEM_IND;
          end
        end
        ST_MEM_RW: begin
          if (exec_cls_s.is_load) begin
            mem_state        = MS_READ;
            enable_writeback = complete_data;
          end else if (exec_cls_s.is_store) begin
            mem_state = MS_WRITE;
          end else begin
            mem_state = MS_IDLE;
          end
          if (complete_data) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_MEM_RW;
          end
        end
        ST_BR1: begin
          enable_execute   = 1'b1;
          enable_writeback = 1'b1;
          state_d          = ST_BR2;
        end
        ST_BR2: begin
          enable_execute   = 1'b1;
          enable_writeback = 1'b1;
          enable_updatePC  = 1'b1;
          br_taken         = exec_cls_s.is_jmp || ((IR_Exec[11:9] & psr) != 3'b000);
          state_d          = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_lc3_controller.sv
// Cycle-stepped bench: each scenario queues stimulus with its expected
// outputs, then plays it back and compares against the scoreboard.
module tb_lc3_controller;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IMem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
  logic        br_taken;
  logic [1:0]  mem_state;

  lc3_controller dut (
    .clock(clock), .reset(reset), .complete_instr(complete_instr),
    .complete_data(complete_data), .IMem_dout(IMem_dout), .IR(IR),
    .IR_Exec(IR_Exec), .psr(psr), .enable_fetch(enable_fetch),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .enable_updatePC(enable_updatePC),
    .br_taken(br_taken), .mem_state(mem_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected vector: {fetch, decode, execute, writeback, updatePC, br_taken, mem_state}
  localparam logic [7:0] E_RUN   = {5'b11111, 1'b0, 2'd3};
  localparam logic [7:0] E_IDLE  = {5'b00000, 1'b0, 2'd3};
  localparam logic [7:0] E_IND   = {5'b00000, 1'b0, 2'd2};
  localparam logic [7:0] E_RD    = {5'b00000, 1'b0, 2'd0};
  localparam logic [7:0] E_RD_WB = {5'b00010, 1'b0, 2'd0};
  localparam logic [7:0] E_WR    = {5'b00000, 1'b0, 2'd1};
  localparam logic [7:0] E_BR1   = {5'b00110, 1'b0, 2'd3};
  localparam logic [7:0] E_BR2_T = {5'b00111, 1'b1, 2'd3};
  localparam logic [7:0] E_BR2_N = {5'b00111, 1'b0, 2'd3};

  localparam logic [15:0] I_ADD = 16'h1261;
  localparam logic [15:0] I_LDR = 16'h6442;
  localparam logic [15:0] I_STI = 16'hB602;
  localparam logic [15:0] I_LD  = 16'h2002;
  localparam logic [15:0] I_LDI = 16'hA402;
  localparam logic [15:0] I_BRZ = 16'h0402;
  localparam logic [15:0] I_JMP = 16'hC1C0;

  typedef struct packed {
    logic        rst;
    logic        ci;
    logic        cd;
    logic [15:0] imem;
    logic [15:0] ir;
    logic [15:0] irx;
    logic [2:0]  psr;
    logic [7:0]  exp;
  } stim_t;

  stim_t      stim_q[$];
  logic [7:0] sb_q[$];
  logic [7:0] obs_s;
  int         n_run  = 0;
  int         n_fail = 0;

  assign obs_s = {enable_fetch, enable_decode, enable_execute, enable_writeback,
                  enable_updatePC, br_taken, mem_state};

  task automatic add(input logic rst, input logic ci, input logic cd,
                     input logic [15:0] imem, input logic [15:0] ir,
                     input logic [15:0] irx, input logic [2:0] p, input logic [7:0] exp);
    stim_t s;
    s = '{rst: rst, ci: ci, cd: cd, imem: imem, ir: ir, irx: irx, psr: p, exp: exp};
    stim_q.push_back(s);
  endtask

  // Drive one queued cycle at the falling edge and post its expectation.
  task automatic apply_next();
    stim_t s;
    s = stim_q.pop_front();
    reset = s.rst; complete_instr = s.ci; complete_data = s.cd;
    IMem_dout = s.imem; IR = s.ir; IR_Exec = s.irx; psr = s.psr;
    sb_q.push_back(s.exp);
    #2;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    add(1'b1, 1'b1, 1'b1, I_BRZ, I_LDR, I_STI, 3'b111, E_IDLE);
    add(1'b1, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b000, E_IDLE);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b000, E_RUN);
    for (int k = 0; stim_q.size() != 0; k++) begin
      apply_next();
      e = sb_q.pop_front(); n_run++;
      if (obs_s !== e) begin n_fail++; $display("FAIL reset[%0d]: got %b want %b", k, obs_s, e); end
      @(negedge clock);
    end
  endtask

  task automatic test_add_stream();
    logic [7:0] e;
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b010, E_RUN);
    add(1'b0, 1'b0, 1'b0, I_BRZ, I_ADD, I_ADD, 3'b010, E_IDLE);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b010, E_RUN);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b010, E_RUN);
    for (int k = 0; stim_q.size() != 0; k++) begin
      apply_next();
      e = sb_q.pop_front(); n_run++;
      if (obs_s !== e) begin n_fail++; $display("FAIL add_stream[%0d]: got %b want %b", k, obs_s, e); end
      @(negedge clock);
    end
  endtask

  task automatic test_ldr();
    logic [7:0] e;
    add(1'b0, 1'b1, 1'b0, I_ADD, I_LDR, I_ADD, 3'b000, E_RUN);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b0, I_ADD, I_ADD, I_LDR, 3'b000, E_RD);
    add(1'b0, 1'b0, 1'b1, I_ADD, I_ADD, I_LDR, 3'b000, E_RD_WB);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_LDR, 3'b000, E_RUN);
    for (int k = 0; stim_q.size() != 0; k++) begin
      apply_next();
      e = sb_q.pop_front(); n_run++;
      if (obs_s !== e) begin n_fail++; $display("FAIL ldr[%0d]: got %b want %b", k, obs_s, e); end
      @(negedge clock);
    end
  endtask

  task automatic test_sti();
    logic [7:0] e;
    add(1'b0, 1'b1, 1'b0, I_ADD, I_STI, I_ADD, 3'b000, E_RUN);
    add(1'b0, 1'b0, 1'b0, I_ADD, I_ADD, I_STI, 3'b000, E_IND);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_STI, 3'b000, E_IND);
    add(1'b0, 1'b0, 1'b1, I_ADD, I_ADD, I_STI, 3'b000, E_IND);
    add(1'b0, 1'b0, 1'b0, I_ADD, I_ADD, I_STI, 3'b000, E_WR);
    add(1'b0, 1'b0, 1'b1, I_ADD, I_ADD, I_STI, 3'b000, E_WR);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_STI, 3'b000, E_RUN);
    for (int k = 0; stim_q.size() != 0; k++) begin
      apply_next();
      e = sb_q.pop_front(); n_run++;
      if (obs_s !== e) begin n_fail++; $display("FAIL sti[%0d]: got %b want %b", k, obs_s, e); end
      @(negedge clock);
    end
  endtask

  task automatic test_branch();
    logic [7:0] e;
    // BRz taken; BR1 ignores complete_instr and never asserts br_taken.
    add(1'b0, 1'b1, 1'b0, I_BRZ, I_ADD, I_ADD, 3'b010, E_RUN);
    add(1'b0, 1'b0, 1'b0, I_ADD, I_ADD, I_BRZ, 3'b010, E_BR1);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_BRZ, I_BRZ, 3'b010, E_BR2_T);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b010, E_RUN);
    // BRz not taken with P set.
    add(1'b0, 1'b1, 1'b0, I_BRZ, I_ADD, I_ADD, 3'b001, E_RUN);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_BRZ, 3'b001, E_BR1);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_BRZ, I_BRZ, 3'b001, E_BR2_N);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b001, E_RUN);
    // JMP always taken regardless of psr.
    add(1'b0, 1'b1, 1'b0, I_JMP, I_ADD, I_ADD, 3'b000, E_RUN);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_JMP, I_JMP, 3'b000, E_BR1);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_JMP, I_JMP, 3'b000, E_BR2_T);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b000, E_RUN);
    for (int k = 0; stim_q.size() != 0; k++) begin
      apply_next();
      e = sb_q.pop_front(); n_run++;
      if (obs_s !== e) begin n_fail++; $display("FAIL branch[%0d]: got %b want %b", k, obs_s, e); end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    // LD in Execute and BR in Decode together: memory sequence first.
    add(1'b0, 1'b1, 1'b0, I_BRZ, I_LD,  I_ADD, 3'b100, E_RUN);
    add(1'b0, 1'b1, 1'b0, I_BRZ, I_BRZ, I_LD,  3'b100, E_RD);
    add(1'b0, 1'b1, 1'b1, I_BRZ, I_BRZ, I_LD,  3'b100, E_RD_WB);
    add(1'b0, 1'b1, 1'b0, I_BRZ, I_ADD, I_LD,  3'b100, E_RUN);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_BRZ, I_ADD, 3'b100, E_BR1);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_BRZ, I_BRZ, 3'b100, E_BR2_N);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_ADD, 3'b100, E_RUN);
    for (int k = 0; stim_q.size() != 0; k++) begin
      apply_next();
      e = sb_q.pop_front(); n_run++;
      if (obs_s !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %b want %b", k, obs_s, e); end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] e;
    // Abort during MEM_IND.
    add(1'b0, 1'b1, 1'b0, I_ADD, I_LDI, I_ADD, 3'b000, E_RUN);
    add(1'b0, 1'b0, 1'b0, I_ADD, I_ADD, I_LDI, 3'b000, E_IND);
    add(1'b1, 1'b1, 1'b1, I_ADD, I_ADD, I_LDI, 3'b000, E_IDLE);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_LDI, 3'b000, E_RUN);
    // Abort during BR1.
    add(1'b0, 1'b1, 1'b0, I_BRZ, I_ADD, I_ADD, 3'b010, E_RUN);
    add(1'b1, 1'b1, 1'b0, I_ADD, I_ADD, I_BRZ, 3'b010, E_IDLE);
    add(1'b0, 1'b1, 1'b0, I_ADD, I_ADD, I_BRZ, 3'b010, E_RUN);
    for (int k = 0; stim_q.size() != 0; k++) begin
      apply_next();
      e = sb_q.pop_front(); n_run++;
      if (obs_s !== e) begin n_fail++; $display("FAIL reset_abort[%0d]: got %b want %b", k, obs_s, e); end
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1; complete_instr = 1'b0; complete_data = 1'b0;
    IMem_dout = 16'h0000; IR = 16'h0000; IR_Exec = 16'h0000; psr = 3'b000;
    @(negedge clock);
    test_reset();
    test_add_stream();
    test_ldr();
    test_sti();
    test_branch();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clock.
REQ-002 Port clock  input  1  system clock.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port complete_instr  input  1  instruction memory has valid data this cycle.
REQ-005 Port complete_data  input  1  data memory access completes this cycle.
REQ-006 Port IMem_dout  input  16  instruction presented to Decode this cycle.
REQ-007 Port IR  input  16  instruction in Execute this cycle (Decode IR output).
REQ-008 Port IR_Exec  input  16  instruction that completed Execute last cycle.
REQ-009 Port psr  input  3  N,Z,P condition codes (bit2=N, bit1=Z, bit0=P).
REQ-010 Port enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC  output  1 each  stage enables.
REQ-011 Port br_taken  output  1  load PC from branch/jump target.
REQ-012 Port mem_state  output  2  0=read, 1=write, 2=indirect-address read, 3=idle.

Function
REQ-013 The state register SHALL hold one of RUN, MEM_IND, MEM_RW, BR1, BR2; outputs SHALL be combinational from state and inputs.
REQ-014 Opcode classes (bits 15:12): ALU = 0001, 0101, 1001; LEA = 1110; load = 0010, 0110, 1010; store = 0011, 0111, 1011; indirect = 1010, 1011; control = 0000 (BR), 1100 (JMP).
REQ-015 In RUN with complete_instr=1, all five enables SHALL be 1, mem_state=3 and br_taken=0.
REQ-016 In RUN with complete_instr=0, all enables SHALL be 0; the state SHALL be held.
REQ-017 In RUN, if IR is a load or store, the next state SHALL be MEM_IND if IR is indirect, else MEM_RW; this takes priority over REQ-018.
REQ-018 In RUN, if IMem_dout is a control opcode and enable_decode=1, the next state SHALL be BR1.
REQ-019 In MEM_IND, all enables SHALL be 0 and mem_state=2; on complete_data=1 the next state SHALL be MEM_RW.
REQ-020 In MEM_RW, mem_state SHALL be 0 for loads and 1 for stores, both decoded from IR_Exec, which is stable during the stall; enable_fetch, enable_decode, enable_execute and enable_updatePC SHALL be 0.
REQ-021 In MEM_RW, enable_writeback SHALL equal complete_data for loads and 0 for stores; on complete_data=1 the next state SHALL be RUN.
REQ-022 In BR1, enable_fetch, enable_decode and enable_updatePC SHALL be 0; enable_execute and enable_writeback SHALL be 1; the next state SHALL be BR2 unconditionally.
REQ-023 In BR2, enable_fetch and enable_decode SHALL be 0; enable_updatePC, enable_execute and enable_writeback SHALL be 1; the next state SHALL be RUN.
REQ-024 In BR2, br_taken SHALL be 1 when IR_Exec is JMP or (IR_Exec[11:9] & psr) != 0; otherwise 0. br_taken SHALL be 0 in all other states.
REQ-025 Control-opcode latency: branch decoded at cycle t, PC updated at t+2, fetch resumes at t+3.
REQ-026 Non-memory, non-control instructions SHALL never stall the pipeline while complete_instr=1.

Reset
REQ-027 While reset=1, all enables and br_taken SHALL be 0, mem_state SHALL be 3 and the next state SHALL be RUN.
REQ-028 Reset asserted in any state, including mid-memory access or mid-branch, SHALL abort the sequence; the first cycle after deassertion SHALL be RUN.

Structure
REQ-029 Package lc3_ctrl_pkg SHALL hold the opcode constants, the state enum and the mem_state encodings.
REQ-030 A sub-module lc3_op_classify SHALL map a 16-bit instruction to the class flags of REQ-014; it SHALL be instantiated for IR, IR_Exec and IMem_dout.

Verification
REQ-031 Reset then ADD stream (IMem_dout=16'h1261 repeated, complete_instr=1) -> all enables 1 every cycle, mem_state=3.
REQ-032 IR=LDR (16'h6442) -> state MEM_RW, mem_state=0, enables 0; complete_data pulses after 3 cycles -> enable_writeback=1 that cycle, RUN next.
REQ-033 IR=STI (16'hB602) -> mem_state 2 until first complete_data, then 1 until second complete_data, then RUN; enable_writeback stays 0.
REQ-034 BR with IR_Exec=16'h0402 (Z), psr=3'b010 -> br_taken=1 and enable_updatePC=1 exactly in BR2; psr=3'b001 -> br_taken=0.
REQ-035 LD in IR and BR in IMem_dout in the same cycle -> memory sequence first, BR1 entered only after return to RUN.
REQ-036 Reset asserted during MEM_IND -> outputs at reset values next cycle, RUN after deassertion.
